snax_gemm_tile_seq: RTL and testbench

SNAX_GEMM_TILE_SEQ -- requirements
Module: snax_gemm_tile_seq

---
 rtl/snax_gemm_seq_pkg.sv | 46 ++++
 rtl/snax_gemm_tile_seq_if.sv | 29 ++
 rtl/snax_gemm_tile_agu.sv | 121 ++++++++++++
 rtl/snax_gemm_tile_seq.sv | 197 +++++++++++++++++++
 tb/tb_snax_gemm_tile_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snax_gemm_seq_pkg.sv
// Shared definitions for the GEMM tile sequencer: CSR map, FSM states and
// the address-generator configuration bundle.
package snax_gemm_seq_pkg;

  localparam logic [3:0] CSR_BASE_A     = 4'd0;
  localparam logic [3:0] CSR_BASE_B     = 4'd1;
  localparam logic [3:0] CSR_BASE_C     = 4'd2;
  localparam logic [3:0] CSR_TILES_M    = 4'd3;
  localparam logic [3:0] CSR_TILES_K    = 4'd4;
  localparam logic [3:0] CSR_TILES_N    = 4'd5;
  localparam logic [3:0] CSR_STR_AM     = 4'd6;
  localparam logic [3:0] CSR_STR_AK     = 4'd7;
  localparam logic [3:0] CSR_STR_BK     = 4'd8;
  localparam logic [3:0] CSR_STR_BN     = 4'd9;
  localparam logic [3:0] CSR_STR_CM     = 4'd10;
  localparam logic [3:0] CSR_STR_CN     = 4'd11;
  localparam logic [3:0] CSR_START      = 4'd12;
  localparam logic [3:0] CSR_STATUS     = 4'd13;
  localparam logic [3:0] CSR_TILE_COUNT = 4'd14;
  localparam logic [3:0] CSR_ABORT      = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [31:0] base_c;
    logic [31:0] str_am;
    logic [31:0] str_ak;
    logic [31:0] str_bk;
    logic [31:0] str_bn;
    logic [31:0] str_cm;
    logic [31:0] str_cn;
  } agu_cfg_t;

  function automatic logic [31:0] status_word(input logic aborted,
                                              input logic done,
                                              input logic busy);
    return {29'b0, aborted, done, busy};
  endfunction

endpackage

// File: rtl/snax_gemm_tile_seq_if.sv
// Tile command bundle between the sequencer and a GEMM engine.
// valid/ready: a command transfers on a cycle where start_valid && start_ready;
// the producer keeps start_valid and all payload stable until that cycle.
interface snax_gemm_tile_seq_if #(
  parameter int unsigned AddrWidth = 32
) ();
  logic                 start_valid;
  logic                 start_ready;
  logic [AddrWidth-1:0] addr_a;
  logic [AddrWidth-1:0] addr_b;
  logic [AddrWidth-1:0] addr_c;
  logic                 accumulate;
  logic                 done;

  modport master (
    output start_valid, addr_a, addr_b, addr_c, accumulate,
    input  start_ready, done
  );

  modport slave (
    input  start_valid, addr_a, addr_b, addr_c, accumulate,
    output start_ready, done
  );

  // Payload-only view for the address generator.
  modport agu (
    output addr_a, addr_b, addr_c, accumulate
  );
endinterface

// File: rtl/snax_gemm_tile_agu.sv
// Tile loop counters (m outer, n middle, k inner) with incremental address
// generation; addresses are registers and stay 0 until init.
module snax_gemm_tile_agu
  import snax_gemm_seq_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                init_i,
  input  logic                step_i,
  input  logic                clear_i,
  input  agu_cfg_t            cfg_i,
  input  logic [CntWidth-1:0] tiles_m_i,
  input  logic [CntWidth-1:0] tiles_k_i,
  input  logic [CntWidth-1:0] tiles_n_i,
  output logic                last_o,
  snax_gemm_tile_seq_if.agu   cmd
);

  typedef logic [AddrWidth-1:0] addr_t;

  logic [CntWidth-1:0] cnt_m_q, cnt_m_d, cnt_n_q, cnt_n_d, cnt_k_q, cnt_k_d;
  addr_t a_row_q, a_row_d, b_row_q, b_row_d, c_row_q, c_row_d;
  addr_t addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
  logic  k_last, n_last, m_last;

  assign k_last = (cnt_k_q == tiles_k_i - CntWidth'(1));
  assign n_last = (cnt_n_q == tiles_n_i - CntWidth'(1));
  assign m_last = (cnt_m_q == tiles_m_i - CntWidth'(1));
  assign last_o = k_last && n_last && m_last;

  // Row registers hold BaseA+m*StrAm, BaseB+n*StrBn and BaseC+m*StrCm so every
  // step is a single add per operand.
  always_comb begin
    cnt_m_d  = cnt_m_q;
    cnt_n_d  = cnt_n_q;
    cnt_k_d  = cnt_k_q;
    a_row_d  = a_row_q;
    b_row_d  = b_row_q;
    c_row_d  = c_row_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    if (clear_i) begin
      cnt_m_d  = '0;
      cnt_n_d  = '0;
      cnt_k_d  = '0;
      a_row_d  = '0;
      b_row_d  = '0;
      c_row_d  = '0;
      addr_a_d = '0;
      addr_b_d = '0;
      addr_c_d = '0;
    end else if (init_i) begin
      cnt_m_d  = '0;
      cnt_n_d  = '0;
      cnt_k_d  = '0;
      a_row_d  = addr_t'(cfg_i.base_a);
      b_row_d  = addr_t'(cfg_i.base_b);
      c_row_d  = addr_t'(cfg_i.base_c);
      addr_a_d = addr_t'(cfg_i.base_a);
      addr_b_d = addr_t'(cfg_i.base_b);
      addr_c_d = addr_t'(cfg_i.base_c);
    end else if (step_i) begin
      if (!k_last) begin
        cnt_k_d  = cnt_k_q + CntWidth'(1);
        addr_a_d = addr_a_q + addr_t'(cfg_i.str_ak);
        addr_b_d = addr_b_q + addr_t'(cfg_i.str_bk);
      end else if (!n_last) begin
        cnt_k_d  = '0;
        cnt_n_d  = cnt_n_q + CntWidth'(1);
        b_row_d  = b_row_q + addr_t'(cfg_i.str_bn);
        addr_a_d = a_row_q;
        addr_b_d = b_row_d;
        addr_c_d = addr_c_q + addr_t'(cfg_i.str_cn);
      end else begin
        cnt_k_d  = '0;
        cnt_n_d  = '0;
        cnt_m_d  = cnt_m_q + CntWidth'(1);
        a_row_d  = a_row_q + addr_t'(cfg_i.str_am);
        b_row_d  = addr_t'(cfg_i.base_b);
        c_row_d  = c_row_q + addr_t'(cfg_i.str_cm);
        addr_a_d = a_row_d;
        addr_b_d = b_row_d;
        addr_c_d = c_row_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_m_q  <= '0;
      cnt_n_q  <= '0;
      cnt_k_q  <= '0;
      a_row_q  <= '0;
      b_row_q  <= '0;
      c_row_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else begin
      cnt_m_q  <= cnt_m_d;
      cnt_n_q  <= cnt_n_d;
      cnt_k_q  <= cnt_k_d;
      a_row_q  <= a_row_d;
      b_row_q  <= b_row_d;
      c_row_q  <= c_row_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
    end
  end

  assign cmd.addr_a     = addr_a_q;
  assign cmd.addr_b     = addr_b_q;
  assign cmd.addr_c     = addr_c_q;
  assign cmd.accumulate = (cnt_k_q != '0);

endmodule

// File: rtl/snax_gemm_tile_seq.sv
// CSR-programmed GEMM tile sequencer: walks an M x N x K tile loop and issues
// one start command per tile, waiting for the engine's done pulse in between.
module snax_gemm_tile_seq
  import snax_gemm_seq_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_valid_i,
  output logic                 csr_ready_o,
  input  logic                 csr_write_i,
  input  logic [3:0]           csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic                 csr_rvalid_o,
  output logic [31:0]          csr_rdata_o,
  output logic                 gemm_start_valid_o,
  input  logic                 gemm_start_ready_i,
  output logic [AddrWidth-1:0] gemm_addr_a_o,
  output logic [AddrWidth-1:0] gemm_addr_b_o,
  output logic [AddrWidth-1:0] gemm_addr_c_o,
  output logic                 gemm_accumulate_o,
  input  logic                 gemm_done_i,
  output logic                 busy_o
);

  snax_gemm_tile_seq_if #(.AddrWidth(AddrWidth)) cmd_if ();

  state_e              state_q, state_d;
  agu_cfg_t            cfg_q;
  logic [CntWidth-1:0] tiles_m_q, tiles_k_q, tiles_n_q;
  logic                done_q, aborted_q, abort_pend_q;
  logic [31:0]         tile_cnt_q;
  logic                rvalid_q;
  logic [31:0]         rdata_q, rd_mux;

  logic busy, csr_wr, csr_rd, cfg_wr, start_wr, abort_wr, abort_now, bounds_ok;
  logic agu_init, agu_step, agu_clear, agu_last, tile_done;

  assign busy      = (state_q != ST_IDLE);
  assign csr_wr    = csr_valid_i && csr_write_i;
  assign csr_rd    = csr_valid_i && !csr_write_i;
  assign cfg_wr    = csr_wr && !busy;
  assign start_wr  = cfg_wr && (csr_addr_i == CSR_START);
  assign abort_wr  = csr_wr && busy && (csr_addr_i == CSR_ABORT);
  assign abort_now = abort_pend_q || abort_wr;
  assign bounds_ok = (tiles_m_q != '0) && (tiles_k_q != '0) && (tiles_n_q != '0);
  assign tile_done = (state_q == ST_WAIT) && cmd_if.done;

  always_comb begin
    state_d   = state_q;
    agu_init  = 1'b0;
    agu_step  = 1'b0;
    agu_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr && bounds_ok) begin
          state_d  = ST_ISSUE;
          agu_init = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_if.start_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_if.done) begin
          if (agu_last || abort_now) begin
            state_d   = ST_IDLE;
            agu_clear = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            agu_step = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        agu_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    rd_mux = '0;
    case (csr_addr_i)
      CSR_BASE_A:     rd_mux = cfg_q.base_a;
      CSR_BASE_B:     rd_mux = cfg_q.base_b;
      CSR_BASE_C:     rd_mux = cfg_q.base_c;
      CSR_TILES_M:    rd_mux = 32'(tiles_m_q);
      CSR_TILES_K:    rd_mux = 32'(tiles_k_q);
      CSR_TILES_N:    rd_mux = 32'(tiles_n_q);
      CSR_STR_AM:     rd_mux = cfg_q.str_am;
      CSR_STR_AK:     rd_mux = cfg_q.str_ak;
      CSR_STR_BK:     rd_mux = cfg_q.str_bk;
      CSR_STR_BN:     rd_mux = cfg_q.str_bn;
      CSR_STR_CM:     rd_mux = cfg_q.str_cm;
      CSR_STR_CN:     rd_mux = cfg_q.str_cn;
      CSR_STATUS:     rd_mux = status_word(aborted_q, done_q, busy);
      CSR_TILE_COUNT: rd_mux = tile_cnt_q;
      default:        rd_mux = '0;
    endcase
  end

  // Later assignments win: a tile completion that ends the run must also
  // clear an abort request arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_q        <= '0;
      tiles_m_q    <= '0;
      tiles_k_q    <= '0;
      tiles_n_q    <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      tile_cnt_q   <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (cfg_wr) begin
        case (csr_addr_i)
          CSR_BASE_A:  cfg_q.base_a <= csr_wdata_i;
          CSR_BASE_B:  cfg_q.base_b <= csr_wdata_i;
          CSR_BASE_C:  cfg_q.base_c <= csr_wdata_i;
          CSR_TILES_M: tiles_m_q    <= csr_wdata_i[CntWidth-1:0];
          CSR_TILES_K: tiles_k_q    <= csr_wdata_i[CntWidth-1:0];
          CSR_TILES_N: tiles_n_q    <= csr_wdata_i[CntWidth-1:0];
          CSR_STR_AM:  cfg_q.str_am <= csr_wdata_i;
          CSR_STR_AK:  cfg_q.str_ak <= csr_wdata_i;
          CSR_STR_BK:  cfg_q.str_bk <= csr_wdata_i;
          CSR_STR_BN:  cfg_q.str_bn <= csr_wdata_i;
          CSR_STR_CM:  cfg_q.str_cm <= csr_wdata_i;
          CSR_STR_CN:  cfg_q.str_cn <= csr_wdata_i;
          default: ;
        endcase
      end
      if (start_wr) begin
        if (bounds_ok) begin
          done_q       <= 1'b0;
          aborted_q    <= 1'b0;
          abort_pend_q <= 1'b0;
          tile_cnt_q   <= '0;
        end else begin
          done_q <= 1'b1;
        end
      end
      if (abort_wr) abort_pend_q <= 1'b1;
      if (tile_done) begin
        if (tile_cnt_q != '1) tile_cnt_q <= tile_cnt_q + 32'd1;
        if (agu_last || abort_now) begin
          done_q       <= 1'b1;
          aborted_q    <= abort_now;
          abort_pend_q <= 1'b0;
        end
      end
      rvalid_q <= csr_rd;
      rdata_q  <= csr_rd ? rd_mux : '0;
    end
  end

  snax_gemm_tile_agu #(
    .AddrWidth(AddrWidth),
    .CntWidth (CntWidth)
  ) u_agu (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .init_i   (agu_init),
    .step_i   (agu_step),
    .clear_i  (agu_clear),
    .cfg_i    (cfg_q),
    .tiles_m_i(tiles_m_q),
    .tiles_k_i(tiles_k_q),
    .tiles_n_i(tiles_n_q),
    .last_o   (agu_last),
    .cmd      (cmd_if)
  );

  assign cmd_if.start_valid = (state_q == ST_ISSUE);
  assign cmd_if.start_ready = gemm_start_ready_i;
  assign cmd_if.done        = gemm_done_i;

  assign csr_ready_o        = 1'b1;
  assign csr_rvalid_o       = rvalid_q;
  assign csr_rdata_o        = rdata_q;
  assign gemm_start_valid_o = cmd_if.start_valid;
  assign gemm_addr_a_o      = cmd_if.addr_a;
  assign gemm_addr_b_o      = cmd_if.addr_b;
  assign gemm_addr_c_o      = cmd_if.addr_c;
  assign gemm_accumulate_o  = cmd_if.accumulate;
  assign busy_o             = busy;

endmodule

// File: tb/tb_snax_gemm_tile_seq.sv
// Directed bench for the GEMM tile sequencer: CSR access, tile walk order,
// back-pressure, zero bounds, abort and mid-run reset.
module tb_snax_gemm_tile_seq;
  import snax_gemm_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid, csr_write, csr_ready, csr_rvalid;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy;
  int          compared = 0;
  int          mismatched = 0;

  snax_gemm_tile_seq_if #(.AddrWidth(32)) gemm_bus ();

  snax_gemm_tile_seq #(.AddrWidth(32), .CntWidth(8)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .csr_valid_i       (csr_valid),
    .csr_ready_o       (csr_ready),
    .csr_write_i       (csr_write),
    .csr_addr_i        (csr_addr),
    .csr_wdata_i       (csr_wdata),
    .csr_rvalid_o      (csr_rvalid),
    .csr_rdata_o       (csr_rdata),
    .gemm_start_valid_o(gemm_bus.start_valid),
    .gemm_start_ready_i(gemm_bus.start_ready),
    .gemm_addr_a_o     (gemm_bus.addr_a),
    .gemm_addr_b_o     (gemm_bus.addr_b),
    .gemm_addr_c_o     (gemm_bus.addr_c),
    .gemm_accumulate_o (gemm_bus.accumulate),
    .gemm_done_i       (gemm_bus.done),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (all start and end on a negedge) ----------
  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_valid = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
    @(negedge clk);
    csr_valid = 1'b0;
    v = csr_rvalid;
    d = csr_rdata;
  endtask

  task automatic set_run(input logic [31:0] ba, bb, bc, tm, tk, tn,
                         am, ak, bk, bn, cm, cn);
    csr_wr(CSR_BASE_A, ba); csr_wr(CSR_BASE_B, bb); csr_wr(CSR_BASE_C, bc);
    csr_wr(CSR_TILES_M, tm); csr_wr(CSR_TILES_K, tk); csr_wr(CSR_TILES_N, tn);
    csr_wr(CSR_STR_AM, am); csr_wr(CSR_STR_AK, ak); csr_wr(CSR_STR_BK, bk);
    csr_wr(CSR_STR_BN, bn); csr_wr(CSR_STR_CM, cm); csr_wr(CSR_STR_CN, cn);
  endtask

  // Looks at the current negedge first, then waits up to 50 cycles.
  task automatic wait_cmd(output logic ok, output logic [31:0] a, b, c, output logic acc);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (gemm_bus.start_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    a = gemm_bus.addr_a; b = gemm_bus.addr_b; c = gemm_bus.addr_c;
    acc = gemm_bus.accumulate;
  endtask

  task automatic pulse_done();
    @(negedge clk); gemm_bus.done = 1'b1;
    @(negedge clk); gemm_bus.done = 1'b0;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (gemm_bus.start_valid !== 1'b0) n++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    logic [31:0] d; logic v;
    apply_reset();
    compared++;
    if ({busy, gemm_bus.start_valid, gemm_bus.accumulate, csr_ready, csr_rvalid} !== 5'b00010) begin
      mismatched++;
      $display("FAIL reset_ctl got=%b exp=00010",
               {busy, gemm_bus.start_valid, gemm_bus.accumulate, csr_ready, csr_rvalid});
    end
    compared++;
    if ({gemm_bus.addr_a, gemm_bus.addr_b, gemm_bus.addr_c, csr_rdata} !== 128'd0) begin
      mismatched++;
      $display("FAIL reset_addr got=%h/%h/%h rdata=%h exp=0", gemm_bus.addr_a,
               gemm_bus.addr_b, gemm_bus.addr_c, csr_rdata);
    end
    for (int r = 0; r < 16; r++) begin
      csr_rd(4'(r), d, v);
      compared++;
      if ({v, d} !== {1'b1, 32'd0}) begin
        mismatched++;
        $display("FAIL reset_csr%0d got v=%b d=%h exp v=1 d=0", r, v, d);
      end
    end
  endtask

  task automatic test_csr_rw();
    logic [31:0] d; logic v;
    csr_wr(CSR_BASE_A, 32'h1234_5678);
    csr_rd(CSR_BASE_A, d, v);
    compared++;
    if ({v, d} !== {1'b1, 32'h1234_5678}) begin
      mismatched++; $display("FAIL rw_base_a got v=%b d=%h exp 1234_5678", v, d);
    end
    @(negedge clk);
    compared++;
    if ({csr_rvalid, csr_rdata} !== 33'd0) begin
      mismatched++; $display("FAIL rvalid_drop got v=%b d=%h exp 0", csr_rvalid, csr_rdata);
    end
    csr_wr(CSR_STR_CN, 32'hCAFE_F00D);
    csr_rd(CSR_STR_CN, d, v);
    compared++;
    if (d !== 32'hCAFE_F00D) begin
      mismatched++; $display("FAIL rw_str_cn got=%h exp=cafef00d", d);
    end
    csr_wr(CSR_TILES_M, 32'h0000_01FF);
    csr_rd(CSR_TILES_M, d, v);
    compared++;
    if (d !== 32'h0000_00FF) begin
      mismatched++; $display("FAIL rw_tiles_trunc got=%h exp=000000ff", d);
    end
    csr_wr(CSR_ABORT, 32'h1);
    csr_rd(CSR_ABORT, d, v);
    compared++;
    if (d !== 32'd0) begin
      mismatched++; $display("FAIL rd_abort_wo got=%h exp=0", d);
    end
    csr_rd(CSR_STATUS, d, v);
    compared++;
    if (d !== 32'd0) begin
      mismatched++; $display("FAIL idle_abort_ignored status=%h exp=0", d);
    end
  endtask

  task automatic test_zero_bound();
    logic [31:0] d; logic v; int n;
    set_run(32'h100, 32'h200, 32'h300, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    csr_wr(CSR_START, 32'h1);
    csr_rd(CSR_STATUS, d, v);
    compared++;
    if (d !== 32'h2) begin
      mismatched++; $display("FAIL zero_bound_status got=%h exp=2", d);
    end
    count_valid(10, n);
    compared++;
    if (n !== 0) begin
      mismatched++; $display("FAIL zero_bound_valid got=%0d cycles exp=0", n);
    end
  endtask

  task automatic test_single();
    logic [31:0] a, b, c, d; logic ok, acc, v;
    set_run(32'h100, 32'h200, 32'h300, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    csr_wr(CSR_START, 32'h1);
    wait_cmd(ok, a, b, c, acc);
    compared++;
    if ({ok, a, b, c, acc} !== {1'b1, 32'h100, 32'h200, 32'h300, 1'b0}) begin
      mismatched++;
      $display("FAIL single_cmd got ok=%b a=%h b=%h c=%h acc=%b exp 1 100 200 300 0",
               ok, a, b, c, acc);
    end
    pulse_done();
    csr_rd(CSR_STATUS, d, v);
    compared++;
    if (d !== 32'h2) begin
      mismatched++; $display("FAIL single_status got=%h exp=2", d);
    end
    compared++;
    if ({gemm_bus.addr_a, gemm_bus.addr_b, gemm_bus.addr_c} !== 96'd0) begin
      mismatched++; $display("FAIL idle_addr_zero got=%h/%h/%h exp=0",
                             gemm_bus.addr_a, gemm_bus.addr_b, gemm_bus.addr_c);
    end
    pulse_done();
    csr_rd(CSR_TILE_COUNT, d, v);
    compared++;
    if (d !== 32'd1) begin
      mismatched++; $display("FAIL single_tilecount got=%0d exp=1", d);
    end
  endtask

  task automatic test_loop_order();
    logic [31:0] a, b, c, d; logic ok, acc, v; int n;
    logic [31:0] exp_a [4] = '{32'h0, 32'h8, 32'h40, 32'h48};
    logic [31:0] exp_b [4] = '{32'h0, 32'h40, 32'h0, 32'h40};
    logic [31:0] exp_c [4] = '{32'h0, 32'h0, 32'h80, 32'h80};
    logic        exp_ac[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    set_run(0, 0, 0, 2, 2, 1, 32'h40, 32'h8, 32'h40, 0, 32'h80, 0);
    csr_wr(CSR_START, 32'h1);
    for (int t = 0; t < 4; t++) begin
      wait_cmd(ok, a, b, c, acc);
      compared++;
      if ({ok, a, b, c, acc} !== {1'b1, exp_a[t], exp_b[t], exp_c[t], exp_ac[t]}) begin
        mismatched++;
        $display("FAIL loop_cmd%0d got ok=%b a=%h b=%h c=%h acc=%b exp a=%h b=%h c=%h acc=%b",
                 t, ok, a, b, c, acc, exp_a[t], exp_b[t], exp_c[t], exp_ac[t]);
      end
      pulse_done();
    end
    count_valid(10, n);
    compared++;
    if (n !== 0) begin
      mismatched++; $display("FAIL loop_extra_cmd got=%0d cycles exp=0", n);
    end
    csr_rd(CSR_TILE_COUNT, d, v);
    compared++;
    if (d !== 32'd4) begin
      mismatched++; $display("FAIL loop_tilecount got=%0d exp=4", d);
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] a, b, c, d; logic ok, acc, v; int n;
    set_run(32'hA00, 32'hB00, 32'hC00, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    gemm_bus.start_ready = 1'b0;
    csr_wr(CSR_START, 32'h1);
    wait_cmd(ok, a, b, c, acc);
    compared++;
    if ({ok, a, b, c} !== {1'b1, 32'hA00, 32'hB00, 32'hC00}) begin
      mismatched++; $display("FAIL stall_cmd got ok=%b a=%h b=%h c=%h exp 1 a00 b00 c00",
                             ok, a, b, c);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({gemm_bus.start_valid, gemm_bus.addr_a, gemm_bus.addr_b, gemm_bus.addr_c} !==
          {1'b1, 32'hA00, 32'hB00, 32'hC00}) begin
        mismatched++;
        $display("FAIL stall_hold%0d got v=%b a=%h b=%h c=%h exp 1 a00 b00 c00", i,
                 gemm_bus.start_valid, gemm_bus.addr_a, gemm_bus.addr_b, gemm_bus.addr_c);
      end
      gemm_bus.done = (i == 1);
    end
    csr_wr(CSR_BASE_A, 32'hDEAD);
    csr_rd(CSR_STATUS, d, v);
    compared++;
    if (d !== 32'h1) begin
      mismatched++; $display("FAIL busy_status got=%h exp=1", d);
    end
    gemm_bus.start_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (gemm_bus.start_valid !== 1'b0) begin
      mismatched++; $display("FAIL stall_release valid=%b exp=0", gemm_bus.start_valid);
    end
    pulse_done();
    count_valid(5, n);
    compared++;
    if (n !== 0) begin
      mismatched++; $display("FAIL stall_single_hs got=%0d cycles exp=0", n);
    end
    csr_rd(CSR_TILE_COUNT, d, v);
    compared++;
    if (d !== 32'd1) begin
      mismatched++; $display("FAIL stall_tilecount got=%0d exp=1", d);
    end
    csr_rd(CSR_BASE_A, d, v);
    compared++;
    if (d !== 32'hA00) begin
      mismatched++; $display("FAIL busy_write_dropped got=%h exp=a00", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] a, b, c, d; logic ok, acc, v; int n;
    set_run(32'h1000, 0, 0, 4, 1, 1, 32'h10, 0, 0, 0, 0, 0);
    csr_wr(CSR_START, 32'h1);
    for (int t = 0; t < 2; t++) begin
      wait_cmd(ok, a, b, c, acc);
      compared++;
      if ({ok, a} !== {1'b1, 32'h1000 + 32'h10 * 32'(t)}) begin
        mismatched++; $display("FAIL abort_cmd%0d got ok=%b a=%h exp a=%h", t, ok, a,
                               32'h1000 + 32'h10 * 32'(t));
      end
      if (t == 1) csr_wr(CSR_ABORT, 32'h1);
      pulse_done();
    end
    count_valid(20, n);
    compared++;
    if (n !== 0) begin
      mismatched++; $display("FAIL abort_extra_cmd got=%0d cycles exp=0", n);
    end
    csr_rd(CSR_STATUS, d, v);
    compared++;
    if (d !== 32'h6) begin
      mismatched++; $display("FAIL abort_status got=%h exp=6", d);
    end
    csr_rd(CSR_TILE_COUNT, d, v);
    compared++;
    if (d !== 32'd2) begin
      mismatched++; $display("FAIL abort_tilecount got=%0d exp=2", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, c, d; logic ok, acc, v; int n;
    set_run(32'h100, 32'h200, 32'h300, 4, 1, 1, 32'h10, 0, 0, 0, 0, 0);
    csr_wr(CSR_START, 32'h1);
    wait_cmd(ok, a, b, c, acc);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compared++;
    if ({ok, busy, gemm_bus.start_valid} !== 3'b100) begin
      mismatched++; $display("FAIL midreset_state got ok/busy/valid=%b exp=100",
                             {ok, busy, gemm_bus.start_valid});
    end
    pulse_done();
    count_valid(20, n);
    compared++;
    if (n !== 0) begin
      mismatched++; $display("FAIL midreset_cmd got=%0d cycles exp=0", n);
    end
    for (int r = 0; r < 16; r++) begin
      csr_rd(4'(r), d, v);
      compared++;
      if (d !== 32'd0) begin
        mismatched++; $display("FAIL midreset_csr%0d got=%h exp=0", r, d);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;
    gemm_bus.start_ready = 1'b1;
    gemm_bus.done = 1'b0;
    test_reset();
    test_csr_rw();
    test_zero_bound();
    test_single();
    test_loop_order();
    test_ready_stall();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
